// File: rtl/sdram_wbuf.sv
// sdram_wbuf: host-side write buffer and read sequencer in front of an SDRAM
// controller. Host writes are queued in a small FIFO and drained one at a time
// through a toggle handshake (we/we_ack). Host reads go through a rising-edge
// request (rd/rd_rdy) and are never in flight together with a write.
// Optional feature macro: SDRAM_WBUF_FWD_EN. When defined, a host read is first
// looked up in the write FIFO (newest entry first). On a hit it is answered
// locally. On a miss it goes to the SDRAM ahead of queued writes. When the
// macro is undefined, a read waits until every earlier write has drained.
module sdram_wbuf #(
    parameter int DEPTH = 4,
    parameter int GAP   = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [24:0] h_addr,
    input  logic [7:0]  h_din,
    input  logic        h_wr,
    input  logic        h_rd,
    output logic        h_wr_rdy,
    output logic        h_rd_rdy,
    output logic [7:0]  h_dout,
    output logic        h_rd_valid,
    output logic [24:0] raddr,
    output logic        rd,
    input  logic        rd_rdy,
    input  logic [7:0]  sd_dout,
    output logic [24:0] waddr,
    output logic [7:0]  din,
    output logic        we,
    input  logic        we_ack
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {W_SYNC, W_IDLE, W_BUSY} wstate_t;
    typedef enum logic [2:0] {R_IDLE, R_PEND, R_REQ, R_WAIT, R_GAP} rstate_t;

    wstate_t        r_wstate;
    wstate_t        w_wstate_nxt;
    rstate_t        r_rstate;
    rstate_t        w_rstate_nxt;

    logic [24:0]    r_fifo_addr [DEPTH];
    logic [7:0]     r_fifo_data [DEPTH];
    logic [AW-1:0]  r_head;
    logic [AW-1:0]  r_tail;
    logic [CW-1:0]  r_count;
    logic [GW-1:0]  r_gap_cnt;
    logic [24:0]    r_rd_addr;

    logic           r_we;
    logic           r_rd;
    logic [24:0]    r_raddr;
    logic [24:0]    r_waddr;
    logic [7:0]     r_din;
    logic [7:0]     r_h_dout;
    logic           r_h_rd_valid;

    logic           w_push;
    logic           w_pop;
    logic           w_rd_acc;
    logic           w_fifo_empty;
    logic           w_we_synced;
    logic           w_wr_start;
    logic           w_rd_issue;
    logic           w_fwd_hit;
`ifdef SDRAM_WBUF_FWD_EN
    logic [7:0]     w_fwd_data;
    logic [AW-1:0]  w_idx;
`endif

    assign h_wr_rdy     = (r_count != CW'(DEPTH));
    assign h_rd_rdy     = (r_rstate == R_IDLE);
    assign w_push       = h_wr & h_wr_rdy;
    assign w_rd_acc     = h_rd & h_rd_rdy;
    assign w_fifo_empty = (r_count == CW'(0));
    assign w_we_synced  = (r_we == we_ack);
    assign w_pop        = (r_wstate == W_BUSY) & w_we_synced;

`ifdef SDRAM_WBUF_FWD_EN
    // Newest-first FIFO lookup; a same-cycle host write shares h_addr so it always wins
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = 8'h00;
        w_idx      = r_head;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + AW'(i);
            if ((CW'(i) < r_count) && (r_fifo_addr[w_idx] == h_addr)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_fifo_data[w_idx];
            end else begin
                w_fwd_hit  = w_fwd_hit;
                w_fwd_data = w_fwd_data;
            end
        end
        if (w_push) begin
            w_fwd_hit  = 1'b1;
            w_fwd_data = h_din;
        end else begin
            w_fwd_hit  = w_fwd_hit;
            w_fwd_data = w_fwd_data;
        end
    end

    // A read waiting in R_PEND (or arriving now and missing) beats FIFO drain
    assign w_wr_start = (r_wstate == W_IDLE) & ~w_fifo_empty & (r_rstate == R_IDLE)
                        & ~(w_rd_acc & ~w_fwd_hit);
    assign w_rd_issue = (r_rstate == R_PEND) & (r_wstate == W_IDLE) & w_we_synced;
`else
    assign w_fwd_hit  = 1'b0;
    // Without forwarding a pending read cannot go until the FIFO is empty, so drain continues
    assign w_wr_start = (r_wstate == W_IDLE) & ~w_fifo_empty
                        & ((r_rstate == R_IDLE) | (r_rstate == R_PEND));
    assign w_rd_issue = (r_rstate == R_PEND) & (r_wstate == W_IDLE) & w_we_synced & w_fifo_empty;
`endif

    // Write FSM next-state
    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_SYNC: w_wstate_nxt = W_IDLE;
            W_IDLE: begin
                if (w_wr_start) begin
                    w_wstate_nxt = W_BUSY;
                end else begin
                    w_wstate_nxt = W_IDLE;
                end
            end
            W_BUSY: begin
                if (w_pop) begin
                    w_wstate_nxt = W_IDLE;
                end else begin
                    w_wstate_nxt = W_BUSY;
                end
            end
            default: w_wstate_nxt = W_SYNC;
        endcase
    end

    // Read FSM next-state
    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE: begin
                if (w_rd_acc && !w_fwd_hit) begin
                    w_rstate_nxt = R_PEND;
                end else begin
                    w_rstate_nxt = R_IDLE;
                end
            end
            R_PEND: begin
                if (w_rd_issue) begin
                    w_rstate_nxt = R_REQ;
                end else begin
                    w_rstate_nxt = R_PEND;
                end
            end
            R_REQ: begin
                if (!rd_rdy) begin
                    w_rstate_nxt = R_WAIT;
                end else begin
                    w_rstate_nxt = R_REQ;
                end
            end
            R_WAIT: begin
                if (rd_rdy) begin
                    w_rstate_nxt = R_GAP;
                end else begin
                    w_rstate_nxt = R_WAIT;
                end
            end
            R_GAP: begin
                if (r_gap_cnt == GW'(GAP - 1)) begin
                    w_rstate_nxt = R_IDLE;
                end else begin
                    w_rstate_nxt = R_GAP;
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // FSM state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wstate <= W_SYNC;
            r_rstate <= R_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
        end
    end

    // Write FIFO storage and pointers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_addr[i] <= 25'h0;
                r_fifo_data[i] <= 8'h00;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_fifo_addr[r_tail] <= h_addr;
                r_fifo_data[r_tail] <= h_din;
                r_tail              <= r_tail + AW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // SDRAM write handshake: realign after reset, present head entry and toggle we
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_we    <= 1'b0;
            r_waddr <= 25'h0;
            r_din   <= 8'h00;
        end else if (r_wstate == W_SYNC) begin
            r_we <= we_ack;
        end else if (w_wr_start) begin
            r_waddr <= r_fifo_addr[r_head];
            r_din   <= r_fifo_data[r_head];
            r_we    <= ~r_we;
        end
    end

    // Read path: address latch, rd request, data capture, completion pulse and gap timer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_addr    <= 25'h0;
            r_raddr      <= 25'h0;
            r_rd         <= 1'b0;
            r_h_dout     <= 8'h00;
            r_h_rd_valid <= 1'b0;
            r_gap_cnt    <= '0;
        end else begin
            r_h_rd_valid <= 1'b0;
            if (w_rd_acc && !w_fwd_hit) begin
                r_rd_addr <= h_addr;
            end
`ifdef SDRAM_WBUF_FWD_EN
            if (w_rd_acc && w_fwd_hit) begin
                r_h_dout     <= w_fwd_data;
                r_h_rd_valid <= 1'b1;
            end
`endif
            if (w_rd_issue) begin
                r_raddr <= r_rd_addr;
                r_rd    <= 1'b1;
            end
            if ((r_rstate == R_WAIT) && rd_rdy) begin
                r_h_dout     <= sd_dout;
                r_h_rd_valid <= 1'b1;
                r_rd         <= 1'b0;
            end
            if (r_rstate == R_GAP) begin
                r_gap_cnt <= r_gap_cnt + GW'(1);
            end else begin
                r_gap_cnt <= '0;
            end
        end
    end

    assign we         = r_we;
    assign waddr      = r_waddr;
    assign din        = r_din;
    assign rd         = r_rd;
    assign raddr      = r_raddr;
    assign h_dout     = r_h_dout;
    assign h_rd_valid = r_h_rd_valid;

endmodule

// File: tb/tb_sdram_wbuf.sv
// Testbench for sdram_wbuf: randomized SDRAM controller model plus a
// behavioural memory reference (last host write wins, reset discards queued
// writes). Expectations follow SDRAM_WBUF_FWD_EN when it is defined.
module tb_sdram_wbuf;

    localparam int DEPTH = 4;
    localparam int GAP   = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [24:0] h_addr = 25'h0;
    logic [7:0]  h_din = 8'h00;
    logic        h_wr = 1'b0;
    logic        h_rd = 1'b0;
    logic        h_wr_rdy, h_rd_rdy, h_rd_valid, rd, we;
    logic [7:0]  h_dout, din;
    logic [24:0] raddr, waddr;
    logic        rd_rdy = 1'b1;
    logic [7:0]  sd_dout = 8'h00;
    logic        we_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    // SDRAM model state (written only by the model process)
    logic [7:0]  mem [logic [24:0]];
    logic [24:0] wlog [$];
    int          q_gap [$];
    int          cyc = 0, wr_count = 0, rd_count = 0, proto_viol = 0;
    int          last_lat = 0, rdy_cyc = 0, fall_cyc = 0;
    int          wcnt = 0, wdelay = 2, rcnt = 0, rlat = 1;
    bit          has_fall = 1'b0, pend_seen = 1'b0, rbusy = 1'b0, prev_rd = 1'b0;
    logic [24:0] pend_addr = 25'h0, r_lat_addr = 25'h0;
    logic [7:0]  pend_data = 8'h00;

    // Knobs written only by the stimulus
    bit ack_en = 1'b1;
    bit ack_reset_val = 1'b0;

    // Reference memory (written only by the stimulus)
    logic [7:0] exp_mem [logic [24:0]];

    sdram_wbuf #(.DEPTH(DEPTH), .GAP(GAP)) dut (
        .clk(clk), .reset_n(reset_n), .h_addr(h_addr), .h_din(h_din),
        .h_wr(h_wr), .h_rd(h_rd), .h_wr_rdy(h_wr_rdy), .h_rd_rdy(h_rd_rdy),
        .h_dout(h_dout), .h_rd_valid(h_rd_valid), .raddr(raddr), .rd(rd),
        .rd_rdy(rd_rdy), .sd_dout(sd_dout), .waddr(waddr), .din(din),
        .we(we), .we_ack(we_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input logic [24:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] sdram_byte(input logic [24:0] a);
        return mem.exists(a) ? mem[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] exp_byte(input logic [24:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : init_byte(a);
    endfunction

    // SDRAM controller model with random latencies and protocol monitoring
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!reset_n) begin
            we_ack    = ack_reset_val;
            rd_rdy    = 1'b1;
            pend_seen = 1'b0;
            rbusy     = 1'b0;
            prev_rd   = 1'b0;
            wcnt      = 0;
        end else begin
            if (rd && !prev_rd) begin
                if (we !== we_ack) proto_viol++;
                if (has_fall) q_gap.push_back(cyc - fall_cyc);
                rd_count++;
                rbusy      = 1'b1;
                rcnt       = 0;
                rlat       = int'($urandom_range(3, 1));
                r_lat_addr = raddr;
                rd_rdy     = 1'b0;
            end else if (rbusy) begin
                rcnt++;
                if (rcnt >= rlat) begin
                    sd_dout = sdram_byte(r_lat_addr);
                    rd_rdy  = 1'b1;
                    rbusy   = 1'b0;
                    rdy_cyc = cyc;
                end
            end
            if (prev_rd && !rd) begin
                fall_cyc = cyc;
                has_fall = 1'b1;
            end
            prev_rd = rd;
            if (h_rd_valid) last_lat = cyc - rdy_cyc;
            if (we !== we_ack) begin
                if (!pend_seen) begin
                    if (rd || rbusy) proto_viol++;
                    pend_seen = 1'b1;
                    pend_addr = waddr;
                    pend_data = din;
                    wcnt      = 0;
                    wdelay    = int'($urandom_range(4, 2));
                end else if ((waddr !== pend_addr) || (din !== pend_data)) begin
                    proto_viol++;
                end
                if (ack_en) begin
                    wcnt++;
                    if (wcnt >= wdelay) begin
                        mem[waddr] = din;
                        wlog.push_back(waddr);
                        wr_count++;
                        we_ack    = ~we_ack;
                        pend_seen = 1'b0;
                    end
                end
            end else begin
                pend_seen = 1'b0;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic host_write(input logic [24:0] a, input logic [7:0] d);
        int n;
        for (n = 0; n < 500 && !h_wr_rdy; n++) step();
        if (!h_wr_rdy) begin
            checks++; errors++;
            $display("FAIL wr_rdy_timeout addr=%h got h_wr_rdy=%b want 1", a, h_wr_rdy);
        end
        h_addr = a; h_din = d; h_wr = 1'b1;
        exp_mem[a] = d;
        step();
        h_wr = 1'b0;
    endtask

    task automatic host_read(input logic [24:0] a, output logic [7:0] d, output int lat);
        int n;
        for (n = 0; n < 500 && !h_rd_rdy; n++) step();
        if (!h_rd_rdy) begin
            checks++; errors++;
            $display("FAIL rd_rdy_timeout addr=%h got h_rd_rdy=%b want 1", a, h_rd_rdy);
        end
        h_addr = a; h_rd = 1'b1;
        step();
        h_rd = 1'b0;
        for (lat = 1; lat < 500 && !h_rd_valid; lat++) step();
        d = h_dout;
        if (!h_rd_valid) begin
            checks++; errors++;
            d = 8'hxx;
            $display("FAIL rd_valid_timeout addr=%h got no h_rd_valid want pulse", a);
        end
        step();
    endtask

    task automatic test_reset();
        repeat (3) step();
        checks++; if ({rd, we, h_rd_valid} !== 3'b000) begin errors++;
            $display("FAIL reset_ctrl got rd/we/valid=%b want 000", {rd, we, h_rd_valid}); end
        checks++; if ({raddr, waddr} !== 50'h0) begin errors++;
            $display("FAIL reset_addr got raddr=%h waddr=%h want 0", raddr, waddr); end
        checks++; if ({h_dout, din} !== 16'h0) begin errors++;
            $display("FAIL reset_data got h_dout=%h din=%h want 0", h_dout, din); end
        checks++; if ({h_wr_rdy, h_rd_rdy} !== 2'b11) begin errors++;
            $display("FAIL reset_rdy got wr_rdy/rd_rdy=%b want 11", {h_wr_rdy, h_rd_rdy}); end
        reset_n = 1'b1;
        repeat (3) step();
        checks++; if (we !== we_ack) begin errors++;
            $display("FAIL reset_sync got we=%b want %b", we, we_ack); end
    endtask

    task automatic test_fill();
        int wbase, lbase;
        wbase = wr_count;
        lbase = wlog.size();
        ack_en = 1'b0;
        for (int i = 0; i < 4; i++) host_write(25'h000010 + 25'(i), 8'hA0 + 8'(i));
        checks++; if (h_wr_rdy !== 1'b0) begin errors++;
            $display("FAIL fill_full got h_wr_rdy=%b want 0", h_wr_rdy); end
        ack_en = 1'b1;
        repeat (60) step();
        checks++; if (wr_count - wbase != 4) begin errors++;
            $display("FAIL fill_toggles got %0d want 4", wr_count - wbase); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ((wlog.size() <= lbase + i) || (wlog[lbase + i] !== 25'h000010 + 25'(i))) begin
                errors++;
                $display("FAIL fill_order idx=%0d got %h want %h", i,
                         (wlog.size() > lbase + i) ? wlog[lbase + i] : 25'h1FFFFFF, 25'h000010 + 25'(i));
            end
            checks++;
            if (sdram_byte(25'h000010 + 25'(i)) !== 8'hA0 + 8'(i)) begin
                errors++;
                $display("FAIL fill_data idx=%0d got %h want %h", i,
                         sdram_byte(25'h000010 + 25'(i)), 8'hA0 + 8'(i));
            end
        end
    endtask

    task automatic test_raw();
        logic [7:0] d;
        int lat, rc0;
        rc0 = rd_count;
        host_write(25'h001234, 8'h55);
        host_read(25'h001234, d, lat);
        checks++; if (d !== 8'h55) begin errors++;
            $display("FAIL raw_data got %h want 55", d); end
`ifdef SDRAM_WBUF_FWD_EN
        checks++; if (lat != 1) begin errors++;
            $display("FAIL raw_fwd_latency got %0d want 1", lat); end
        checks++; if (rd_count != rc0) begin errors++;
            $display("FAIL raw_fwd_no_sdram got %0d reads want 0", rd_count - rc0); end
`else
        checks++; if (rd_count != rc0 + 1) begin errors++;
            $display("FAIL raw_sdram_read got %0d reads want 1", rd_count - rc0); end
`endif
        repeat (20) step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] d0, d1;
        int lat, g0;
        g0 = q_gap.size();
        host_read(25'h000100, d0, lat);
        checks++; if (last_lat != 1) begin errors++;
            $display("FAIL read_latency got %0d want 1", last_lat); end
        host_read(25'h000101, d1, lat);
        checks++; if (d0 !== exp_byte(25'h000100)) begin errors++;
            $display("FAIL b2b_data0 got %h want %h", d0, exp_byte(25'h000100)); end
        checks++; if (d1 !== exp_byte(25'h000101)) begin errors++;
            $display("FAIL b2b_data1 got %h want %h", d1, exp_byte(25'h000101)); end
        checks++; if ((q_gap.size() <= g0) || (q_gap[q_gap.size() - 1] < GAP)) begin errors++;
            $display("FAIL b2b_gap got %0d want >= %0d",
                     (q_gap.size() > g0) ? q_gap[q_gap.size() - 1] : -1, GAP); end
        repeat (20) step();
    endtask

    task automatic test_same_cycle();
        logic [7:0] d;
        int n, lat;
        for (n = 0; n < 500 && !(h_wr_rdy && h_rd_rdy); n++) step();
        h_addr = 25'h000200; h_din = 8'h77; h_wr = 1'b1; h_rd = 1'b1;
        exp_mem[25'h000200] = 8'h77;
        step();
        h_wr = 1'b0; h_rd = 1'b0;
        for (lat = 1; lat < 500 && !h_rd_valid; lat++) step();
        d = h_rd_valid ? h_dout : 8'hxx;
        checks++; if (d !== 8'h77) begin errors++;
            $display("FAIL same_cycle got %h want 77", d); end
        repeat (20) step();
    endtask

    task automatic test_random();
        logic [24:0] a;
        logic [7:0] d;
        int lat;
        for (int k = 0; k < 60; k++) begin
            a = 25'h000300 + 25'($urandom_range(7, 0));
            if ($urandom_range(1, 0) == 1) begin
                host_write(a, 8'($urandom));
            end else begin
                host_read(a, d, lat);
                checks++; if (d !== exp_byte(a)) begin errors++;
                    $display("FAIL rand_read addr=%h got %h want %h", a, d, exp_byte(a)); end
            end
            repeat (int'($urandom_range(2, 0))) step();
        end
        repeat (40) step();
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        int lat, wbase;
        ack_en = 1'b0;
        host_write(25'h000400, 8'h11);
        host_write(25'h000401, 8'h22);
        step();
        ack_reset_val = 1'b1;
        reset_n = 1'b0;
        exp_mem.delete(25'h000400);
        exp_mem.delete(25'h000401);
        repeat (2) step();
        checks++; if ({we, rd} !== 2'b00) begin errors++;
            $display("FAIL mid_reset_outs got we/rd=%b want 00", {we, rd}); end
        wbase = wr_count;
        ack_en = 1'b1;
        reset_n = 1'b1;
        repeat (2) step();
        checks++; if (we !== 1'b1) begin errors++;
            $display("FAIL mid_reset_we got %b want 1", we); end
        repeat (20) step();
        checks++; if (wr_count != wbase) begin errors++;
            $display("FAIL mid_reset_spurious got %0d writes want 0", wr_count - wbase); end
        host_read(25'h000400, d, lat);
        checks++; if (d !== exp_byte(25'h000400)) begin errors++;
            $display("FAIL mid_reset_discard got %h want %h", d, exp_byte(25'h000400)); end
        host_write(25'h000402, 8'h99);
        repeat (20) step();
        host_read(25'h000402, d, lat);
        checks++; if (d !== 8'h99) begin errors++;
            $display("FAIL mid_reset_reuse got %h want 99", d); end
        checks++; if (wr_count != wbase + 1) begin errors++;
            $display("FAIL mid_reset_count got %0d writes want 1", wr_count - wbase); end
    endtask

    task automatic test_protocol();
        checks++; if (proto_viol != 0) begin errors++;
            $display("FAIL protocol got %0d violations want 0", proto_viol); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_raw();
        test_back_to_back();
        test_same_cycle();
        test_random();
        test_reset_mid();
        test_protocol();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
